mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Sequences the single shared memory port between the instruction-fetch requester and the data-access (MEM-stage) requester of the 16-bit pipelined CPU. It sits between the pipeline datapath and the memory model. It grants one requester at a time, drives the memory control and address lines for a fixed multi-cycle access, and returns read data with a one-cycle ready pulse. Data requests take priority over instruction fetch.

## Interface
Parameters:
- WORD_SIZE, 16, width of addresses and data words
- MEM_LATENCY, 2, number of cycles the memory lines are held per access; legal range 1..15

Ports:
- clk  in  1  rising-edge clock; this block uses one clock only
- reset_n  in  1  asynchronous, active-low reset
- i_req  in  1  instruction-fetch request; held high until i_ready
- i_addr  in  WORD_SIZE  fetch address; stable while i_req is high
- i_ready  out  1  one-cycle pulse marking fetch completion
- i_data  out  WORD_SIZE  fetched instruction; valid while i_ready is high and held afterwards
- d_req  in  1  data request; held high until d_ready
- d_we  in  1  1 = write, 0 = read; stable while d_req is high
- d_addr  in  WORD_SIZE  data address
- d_wdata  in  WORD_SIZE  write data
- d_ready  out  1  one-cycle pulse marking data-access completion
- d_rdata  out  WORD_SIZE  read data; valid while d_ready is high and held afterwards
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  WORD_SIZE  memory address
- mem_wdata  out  WORD_SIZE  memory write data
- mem_rdata  in  WORD_SIZE  memory read data; valid on the last BUSY cycle

## Operation
States: IDLE, BUSY, DONE. A 1-bit `owner` register selects the requester: 0 = instruction, 1 = data. A 4-bit down-counter `cnt` tracks the access.

- **IDLE**
  - d_req=1: owner←1, cnt←MEM_LATENCY, go to BUSY.
  - Else if i_req=1: owner←0, cnt←MEM_LATENCY, go to BUSY.
  - Else stay in IDLE.
  - Fixed priority: data beats instruction when both are high in the same cycle.
- **BUSY**
  - All mem_* outputs are registered copies of the owner's request, latched on entry.
  - owner=0: mem_read=1, mem_addr=i_addr.
  - owner=1, d_we=0: mem_read=1, mem_addr=d_addr.
  - owner=1, d_we=1: mem_write=1, mem_addr=d_addr, mem_wdata=d_wdata.
  - cnt decrements each cycle.
  - When cnt=1:
    - Capture mem_rdata into i_data (owner=0) or into d_rdata (owner=1, read). Writes leave d_rdata unchanged.
    - Go to DONE.
- **DONE**
  - Owner's ready=1 for exactly this cycle. mem_read=mem_write=0.
  - Unconditionally return to IDLE.
  - No arbitration in DONE. The requester drops req at the edge that ends DONE; a req still high in IDLE is a new access.
- Inputs that change while BUSY are ignored; the latched copy is used.
- A request arriving during another requester's access waits in its req line. It is granted in the next IDLE cycle.
- Outside BUSY: mem_addr and mem_wdata hold their last values; strobes are 0.
- i_ready and d_ready are never high in the same cycle.

## Timing
- Reset (reset_n=0, asynchronous) forces all of the following immediately, including mid-access:
  - state=IDLE, cnt=0, owner=0
  - i_ready=d_ready=0, mem_read=mem_write=0
  - mem_addr=mem_wdata=i_data=d_rdata=0
- An aborted access is not resumed; the requester must re-request after reset.
- With req sampled high in IDLE at edge E0:
  - BUSY occupies cycles E0..E0+MEM_LATENCY−1.
  - ready is high in cycle E0+MEM_LATENCY.
  - IDLE resumes at E0+MEM_LATENCY+1.
- Request-to-ready latency is MEM_LATENCY+1 cycles. Peak throughput is one access per MEM_LATENCY+2 cycles.
- MEM_LATENCY=1: a single BUSY cycle, then DONE.
- The memory must present mem_rdata combinationally or by the last BUSY cycle. The arbiter samples it at the edge leaving BUSY.
- All outputs are registered; no input-to-output combinational path.

## Test plan
- **Reset:** hold reset_n=0 with i_req=d_req=1 → all outputs 0, state IDLE. Release → data granted first; d_ready at cycle 3 (MEM_LATENCY=2).
- **Single fetch:** i_req=1, i_addr=0x0010, mem returns 0x6A03 → mem_read=1, mem_addr=0x0010 for 2 cycles; i_ready pulse one cycle later with i_data=0x6A03; d_ready stays 0.
- **Data write:** d_req=1, d_we=1, d_addr=0x0040, d_wdata=0xBEEF → mem_write=1 for 2 cycles with addr/data matching; d_ready pulses; d_rdata unchanged.
- **Simultaneous:** i_req and d_req both rise together (d read of 0x0041 returns 0x1234) → d_ready first with 0x1234. i_req stays high, granted at the next IDLE; i_ready arrives 4 cycles after d_ready.
- **Mid-access reset:** assert reset_n=0 on the second BUSY cycle → strobes drop asynchronously, no ready pulse. After release with req held → access restarts from IDLE with full latency.
- **Input change during BUSY:** change i_addr from 0x0010 to 0x0020 while BUSY → mem_addr stays 0x0010 for the whole access.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and data access, data first
module mem_port_arbiter #(
  parameter int WORD_SIZE   = 16,
  parameter int MEM_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic                 i_ready,
  output logic [WORD_SIZE-1:0] i_data,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 d_ready,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [3:0] LAT  = 4'(MEM_LATENCY);
  logic [1:0]           state_q, state_d;
  logic                 owner_q, owner_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 rd_q, rd_d, wr_q, wr_d;
  logic                 irdy_q, irdy_d, drdy_q, drdy_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [WORD_SIZE-1:0] idata_q, idata_d, drdata_q, drdata_d;
  // Arbitrate in IDLE, latch the winner's request into the memory lines, count down, then pulse ready
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    irdy_d   = 1'b0;
    drdy_d   = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    idata_d  = idata_q;
    drdata_d = drdata_q;
    case (state_q)
      IDLE: begin
        if (d_req) begin
          state_d = BUSY;
          owner_d = 1'b1;
          cnt_d   = LAT;
          rd_d    = !d_we;
          wr_d    = d_we;
          addr_d  = d_addr;
          wdata_d = d_we ? d_wdata : wdata_q;
        end else if (i_req) begin
          state_d = BUSY;
          owner_d = 1'b0;
          cnt_d   = LAT;
          rd_d    = 1'b1;
          addr_d  = i_addr;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d  = DONE;
          irdy_d   = !owner_q;
          drdy_d   = owner_q;
          idata_d  = owner_q ? idata_q : mem_rdata;
          drdata_d = (owner_q && !wr_q) ? mem_rdata : drdata_q;
        end else begin
          rd_d = rd_q;
          wr_d = wr_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // State and output registers; reset clears everything, abandoning any access in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      cnt_q    <= 4'd0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      irdy_q   <= 1'b0;
      drdy_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      idata_q  <= '0;
      drdata_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      irdy_q   <= irdy_d;
      drdy_q   <= drdy_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      idata_q  <= idata_d;
      drdata_q <= drdata_d;
    end
  end
  assign i_ready   = irdy_q;
  assign d_ready   = drdy_q;
  assign i_data    = idata_q;
  assign d_rdata   = drdata_q;
  assign mem_read  = rd_q;
  assign mem_write = wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
endmodule
